// File: rtl/corelet_pkg.sv
// corelet_pkg: shared FSM state type and accumulator width helper for the SFU
package corelet_pkg;
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;
  function automatic int acc_w(input int psum_bw, input int max_pass);
    return psum_bw + $clog2(max_pass) + 1;
  endfunction
endpackage

// File: rtl/sfu_lane.sv
// sfu_lane: one column's accumulator, residual add, ReLU, saturation and sticky overflow bit
module sfu_lane #(
  parameter int PSUM_BW = 16,
  parameter int ACC_BW = 21
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               add_i,
  input  logic               fin_i,
  input  logic               relu_i,
  input  logic               res_i,
  input  logic               clr_i,
  input  logic [PSUM_BW-1:0] psum_i,
  input  logic [PSUM_BW-1:0] resid_i,
  output logic [PSUM_BW-1:0] out_o,
  output logic               ovf_o
);
  localparam int MAXI = (1 << (PSUM_BW - 1)) - 1;
  localparam logic signed [ACC_BW-1:0] MAXV = ACC_BW'(MAXI);
  localparam logic signed [ACC_BW-1:0] MINV = ACC_BW'(-MAXI - 1);
  logic signed [ACC_BW-1:0] acc_q, acc_d, psum_x, res_x, s, r;
  logic [PSUM_BW-1:0] out_q, out_d;
  logic ovf_q, ovf_d, hi, lo;
  // accumulate the beat, then build the finalised value from the post-beat sum
  always_comb begin
    psum_x = {{(ACC_BW-PSUM_BW){psum_i[PSUM_BW-1]}}, psum_i};
    res_x = {{(ACC_BW-PSUM_BW){resid_i[PSUM_BW-1]}}, resid_i};
    acc_d = load_i ? psum_x : add_i ? acc_q + psum_x : acc_q;
    s = acc_d + (res_i ? res_x : '0);
    r = (relu_i && s[ACC_BW-1]) ? '0 : s;
    hi = r > MAXV;
    lo = r < MINV;
    out_d = fin_i ? (hi ? MAXV[PSUM_BW-1:0] : lo ? MINV[PSUM_BW-1:0] : r[PSUM_BW-1:0]) : out_q;
    ovf_d = (ovf_q & ~clr_i) | (fin_i & (hi | lo));
  end
  // lane state; a fresh clip on the final beat beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end
  assign out_o = out_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/corelet_sfu.sv
// corelet_sfu: multi-pass psum accumulation with residual, ReLU and saturation per column
module corelet_sfu
  import corelet_pkg::*;
#(
  parameter int col = 8,
  parameter int psum_bw = 16,
  parameter int max_pass = 16,
  parameter int cnt_w = $clog2(max_pass) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [psum_bw*col-1:0] psum_in,
  input  logic [cnt_w-1:0]       n_pass,
  input  logic                   mode_relu,
  input  logic                   mode_res,
  input  logic [psum_bw*col-1:0] res_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [psum_bw*col-1:0] out_data,
  output logic                   busy,
  input  logic                   clr_ovf,
  output logic [col-1:0]         ovf_flag
);
  localparam int ACC_BW = acc_w(psum_bw, max_pass);
  state_e state_q, state_d;
  logic [cnt_w-1:0] cnt_q, cnt_d, np_q, np_d, np_in;
  logic relu_q, relu_d, res_q, res_d, beat, first, add, last;
  // state register with pass counter and per-group latches
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      np_q <= '0;
      relu_q <= 1'b0;
      res_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      np_q <= np_d;
      relu_q <= relu_d;
      res_q <= res_d;
    end
  end
  // beat classification and next state; a beat in HOLD implies the result was taken
  always_comb begin
    np_in = (n_pass == '0) ? cnt_w'(1) : (n_pass > cnt_w'(max_pass)) ? cnt_w'(max_pass) : n_pass;
    beat = in_valid & in_ready;
    first = beat & (state_q != ACC);
    add = beat & (state_q == ACC);
    last = first ? (np_in == cnt_w'(1)) : (add && cnt_q == np_q - cnt_w'(1));
    state_d = beat ? (last ? HOLD : ACC) : (state_q == HOLD && out_ready) ? IDLE : state_q;
    cnt_d = first ? cnt_w'(1) : add ? cnt_q + cnt_w'(1) : cnt_q;
    np_d = first ? np_in : np_q;
    relu_d = first ? mode_relu : relu_q;
    res_d = first ? mode_res : res_q;
  end
  // handshake outputs; nothing is accepted while reset is asserted
  always_comb begin
    in_ready = reset && (state_q != HOLD || out_ready);
    out_valid = state_q == HOLD;
    busy = state_q != IDLE;
  end
  for (genvar c = 0; c < col; c++) begin : g_lane
    sfu_lane #(.PSUM_BW(psum_bw), .ACC_BW(ACC_BW)) u_lane (
      .clk(clk),
      .reset(reset),
      .load_i(first),
      .add_i(add),
      .fin_i(last),
      .relu_i(relu_d),
      .res_i(res_d),
      .clr_i(clr_ovf),
      .psum_i(psum_in[c*psum_bw +: psum_bw]),
      .resid_i(res_in[c*psum_bw +: psum_bw]),
      .out_o(out_data[c*psum_bw +: psum_bw]),
      .ovf_o(ovf_flag[c])
    );
  end
endmodule

// File: tb/tb_corelet_sfu.sv
// tb_corelet_sfu: directed self-checking bench for corelet_sfu
module tb_corelet_sfu;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, in_valid, in_ready, mode_relu, mode_res, out_valid, out_ready, busy, clr_ovf;
  logic [127:0] psum_in, res_in, out_data;
  logic [4:0] n_pass;
  logic [7:0] ovf_flag;
  int n_cmp = 0;
  int n_bad = 0;
  corelet_sfu dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .psum_in(psum_in), .n_pass(n_pass), .mode_relu(mode_relu), .mode_res(mode_res),
    .res_in(res_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .clr_ovf(clr_ovf), .ovf_flag(ovf_flag)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] vec(input int lane, input int val);
    logic [127:0] x;
    x = '0;
    x[lane*16 +: 16] = 16'(val);
    return x;
  endfunction
  function automatic logic [15:0] ln(input logic [127:0] d, input int lane);
    return d[lane*16 +: 16];
  endfunction
  task automatic send(input int lane, input int val, input logic [4:0] np, input logic relu,
                      input logic res, input int rv);
    psum_in = vec(lane, val);
    n_pass = np;
    mode_relu = relu;
    mode_res = res;
    res_in = vec(lane, rv);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    mode_relu = 1'b0; mode_res = 1'b0; n_pass = '0; psum_in = '0; res_in = '0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ovf", ovf_flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);
    send(0, 100, 5'd1, 0, 0, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_lane0", ln(out_data, 0), 16'd100);
    chk("t1_busy", busy, 1);
    take();
    chk("t1_busy_after", busy, 0);
    chk("t1_valid_after", out_valid, 0);
    send(0, 5, 5'd0, 0, 0, 0);
    chk("np0_valid", out_valid, 1);
    chk("np0_lane0", ln(out_data, 0), 16'd5);
    take();
    chk("t2_ready0", in_ready, 1);
    send(3, 1000, 5'd4, 0, 0, 0);
    chk("t2_ready1", in_ready, 1);
    send(3, 2000, 5'd1, 0, 0, 0);
    chk("t2_ready2", in_ready, 1);
    send(3, -500, 5'd1, 0, 0, 0);
    chk("t2_ready3", in_ready, 1);
    chk("t2_not_yet", out_valid, 0);
    send(3, 7, 5'd1, 0, 0, 0);
    chk("t2_valid", out_valid, 1);
    chk("t2_lane3", ln(out_data, 3), 16'd2507);
    take();
    send(0, -30, 5'd2, 1, 1, 0);
    send(0, -40, 5'd2, 0, 0, 50);
    chk("t3_valid", out_valid, 1);
    chk("t3_relu0", ln(out_data, 0), 16'd0);
    take();
    send(0, -30, 5'd2, 1, 1, 0);
    send(0, -40, 5'd2, 0, 0, 100);
    chk("t3_res30", ln(out_data, 0), 16'd30);
    take();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("t4_not_yet", out_valid, 0);
      send(7, 30000, 5'd16, 0, 0, 0);
    end
    chk("t4_valid", out_valid, 1);
    chk("t4_sat_pos", ln(out_data, 7), 16'h7fff);
    chk("t4_ovf", ovf_flag, 8'h80);
    take();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t4_clr", ovf_flag, 8'h00);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        chk("t4n_not_yet", out_valid, 0);
        clr_ovf = 1'b1;
      end
      send(7, -30000, 5'd31, 0, 0, 0);
    end
    clr_ovf = 1'b0;
    chk("t4n_valid", out_valid, 1);
    chk("t4n_sat_neg", ln(out_data, 7), 16'h8000);
    chk("t4n_set_wins", ovf_flag, 8'h80);
    take();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    send(1, 11, 5'd1, 0, 0, 0);
    psum_in = vec(1, 22);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_in_ready0", in_ready, 0);
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_data", ln(out_data, 1), 16'd11);
    end
    out_ready = 1'b1;
    #1;
    chk("t5_in_ready1", in_ready, 1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("t5_stream_valid", out_valid, 1);
    chk("t5_stream_data", ln(out_data, 1), 16'd22);
    take();
    chk("t5_idle", busy, 0);
    send(2, 500, 5'd4, 0, 0, 0);
    send(2, 500, 5'd4, 0, 0, 0);
    chk("t6_busy_mid", busy, 1);
    reset = 1'b0;
    tick();
    chk("t6_busy", busy, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_data", out_data, 0);
    chk("t6_acc", dut.g_lane[2].u_lane.acc_q, 0);
    reset = 1'b1;
    tick();
    chk("t6_no_output", out_valid, 0);
    send(2, 9, 5'd1, 0, 0, 0);
    chk("t6_valid9", out_valid, 1);
    chk("t6_lane2", ln(out_data, 2), 16'd9);
    take();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
